// File: rtl/k054000_pkg.sv
// Shared definitions for the 054000 bus master: register map, state encodings
// and the request-buffer byte selector.
package k054000_pkg;

    localparam int         NUM_REGS  = 18;
    localparam logic [4:0] READ_ADDR = 5'h18;

    // Chip addresses in issue order; index i of the request maps to ADDR_ROM[i].
    localparam logic [4:0] ADDR_ROM [NUM_REGS] = '{
        5'h01, 5'h02, 5'h03, 5'h04, 5'h06, 5'h0E, 5'h15, 5'h16, 5'h17,
        5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h07, 5'h0F, 5'h11, 5'h12, 5'h13
    };

    typedef enum logic [1:0] {
        CTL_IDLE,
        CTL_SCAN,
        CTL_WRITE,
        CTL_READ
    } ctl_state_t;

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_W_SETUP,
        BUS_W_STROBE,
        BUS_W_HOLD,
        BUS_R_ACC,
        BUS_R_SAMPLE
    } bus_state_t;

    typedef struct packed {
        logic [23:0] x_a;
        logic [23:0] x_b;
        logic [23:0] y_a;
        logic [23:0] y_b;
        logic [7:0]  x_c;
        logic [7:0]  x_d;
        logic [7:0]  x_e;
        logic [7:0]  y_c;
        logic [7:0]  y_d;
        logic [7:0]  y_e;
    } req_t;

    function automatic logic [7:0] req_byte(input req_t r, input logic [4:0] idx);
        case (idx)
            5'd0:    req_byte = r.x_a[23:16];
            5'd1:    req_byte = r.x_a[15:8];
            5'd2:    req_byte = r.x_a[7:0];
            5'd3:    req_byte = r.x_e;
            5'd4:    req_byte = r.x_d;
            5'd5:    req_byte = r.x_c;
            5'd6:    req_byte = r.x_b[23:16];
            5'd7:    req_byte = r.x_b[15:8];
            5'd8:    req_byte = r.x_b[7:0];
            5'd9:    req_byte = r.y_a[23:16];
            5'd10:   req_byte = r.y_a[15:8];
            5'd11:   req_byte = r.y_a[7:0];
            5'd12:   req_byte = r.y_e;
            5'd13:   req_byte = r.y_d;
            5'd14:   req_byte = r.y_c;
            5'd15:   req_byte = r.y_b[23:16];
            5'd16:   req_byte = r.y_b[15:8];
            5'd17:   req_byte = r.y_b[7:0];
            default: req_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/k054000_bus_cycle.sv
// Single 054000 bus cycle engine: one write (setup/strobe/hold) or one read
// (access then sample of D0). Owns all chip-pin timing.
module k054000_bus_cycle
    import k054000_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int READ_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       rw,
    input  logic [4:0] addr,
    input  logic [7:0] data,
    input  logic       d0_in,
    output logic       busy,
    output logic       done,
    output logic       sampled,
    output logic [4:0] a,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       cs,
    output logic       nwr
);

    bus_state_t phase_reg;
    logic [7:0] cnt_reg;
    logic       accept;

    // A new cycle may chain straight out of a write hold so the final read
    // follows the last write without an idle clock.
    assign accept = go && (phase_reg == BUS_IDLE || phase_reg == BUS_W_HOLD);
    assign busy   = (phase_reg != BUS_IDLE);
    assign done   = (phase_reg == BUS_W_HOLD) || (phase_reg == BUS_R_ACC && cnt_reg == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg <= BUS_IDLE;
            cnt_reg   <= 8'd0;
            a         <= 5'd0;
            d_out     <= 8'h00;
            d_oe      <= 1'b0;
            cs        <= 1'b0;
            nwr       <= 1'b1;
            sampled   <= 1'b0;
        end else begin
            case (phase_reg)
                BUS_W_SETUP: begin
                    nwr       <= 1'b0;
                    cnt_reg   <= 8'(STROBE_CYCLES - 1);
                    phase_reg <= BUS_W_STROBE;
                end
                BUS_W_STROBE: begin
                    if (cnt_reg == 8'd0) begin
                        nwr       <= 1'b1;
                        phase_reg <= BUS_W_HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                BUS_W_HOLD: begin
                    cs        <= 1'b0;
                    d_oe      <= 1'b0;
                    phase_reg <= BUS_IDLE;
                end
                BUS_R_ACC: begin
                    if (cnt_reg == 8'd0) begin
                        sampled   <= d0_in;
                        cs        <= 1'b0;
                        phase_reg <= BUS_R_SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                default: phase_reg <= BUS_IDLE;
            endcase

            if (accept) begin
                a   <= addr;
                cs  <= 1'b1;
                nwr <= 1'b1;
                if (rw) begin
                    d_oe      <= 1'b0;
                    cnt_reg   <= 8'(READ_CYCLES - 1);
                    phase_reg <= BUS_R_ACC;
                end else begin
                    d_out     <= data;
                    d_oe      <= 1'b1;
                    phase_reg <= BUS_W_SETUP;
                end
            end
        end
    end

endmodule

// File: rtl/k054000_master.sv
// Request sequencer for the 054000: latches a request, writes only the
// register bytes that differ from the shadow copy, then reads the hit bit.
module k054000_master
    import k054000_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int READ_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        full,
    input  logic [23:0] x_a,
    input  logic [23:0] y_a,
    input  logic [23:0] x_b,
    input  logic [23:0] y_b,
    input  logic [7:0]  x_c,
    input  logic [7:0]  x_d,
    input  logic [7:0]  x_e,
    input  logic [7:0]  y_c,
    input  logic [7:0]  y_d,
    input  logic [7:0]  y_e,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic [4:0]  a,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic        d0_in,
    output logic        cs,
    output logic        nwr
);

    ctl_state_t state_reg;
    req_t       req_reg;
    logic       full_reg;
    logic [4:0] idx_reg;
    logic       shadow_valid_reg;
    logic [7:0] shadow_mem [NUM_REGS];

    logic [7:0] cur_byte;
    logic       last_idx;
    logic       need_write;
    logic       scan_ok;
    logic       go;
    logic       go_rd;
    logic [4:0] go_addr;
    logic       bus_busy;
    logic       bus_done;

    assign cur_byte   = req_byte(req_reg, idx_reg);
    assign last_idx   = (idx_reg == 5'(NUM_REGS - 1));
    assign need_write = full_reg || !shadow_valid_reg || (cur_byte != shadow_mem[idx_reg]);
    assign scan_ok    = (state_reg == CTL_SCAN) && !bus_busy;

    always_comb begin
        go      = 1'b0;
        go_rd   = 1'b0;
        go_addr = ADDR_ROM[idx_reg];
        if (scan_ok && need_write) begin
            go = 1'b1;
        end else if ((scan_ok || (state_reg == CTL_WRITE && bus_done)) && last_idx) begin
            go      = 1'b1;
            go_rd   = 1'b1;
            go_addr = READ_ADDR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= CTL_IDLE;
            req_reg          <= '0;
            full_reg         <= 1'b0;
            idx_reg          <= 5'd0;
            shadow_valid_reg <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                CTL_IDLE: begin
                    if (start) begin
                        req_reg   <= '{x_a: x_a, x_b: x_b, y_a: y_a, y_b: y_b,
                                       x_c: x_c, x_d: x_d, x_e: x_e,
                                       y_c: y_c, y_d: y_d, y_e: y_e};
                        full_reg  <= full;
                        idx_reg   <= 5'd0;
                        busy      <= 1'b1;
                        state_reg <= CTL_SCAN;
                    end
                end
                CTL_SCAN: begin
                    if (scan_ok) begin
                        if (need_write)    state_reg <= CTL_WRITE;
                        else if (last_idx) state_reg <= CTL_READ;
                        else               idx_reg   <= idx_reg + 5'd1;
                    end
                end
                CTL_WRITE: begin
                    if (bus_done) begin
                        if (last_idx) begin
                            state_reg <= CTL_READ;
                        end else begin
                            idx_reg   <= idx_reg + 5'd1;
                            state_reg <= CTL_SCAN;
                        end
                    end
                end
                CTL_READ: begin
                    if (bus_done) begin
                        busy             <= 1'b0;
                        done             <= 1'b1;
                        shadow_valid_reg <= 1'b1;
                        state_reg        <= CTL_IDLE;
                    end
                end
                default: state_reg <= CTL_IDLE;
            endcase
        end
    end

    // Shadow contents are meaningless until shadow_valid_reg is set, so no reset.
    always_ff @(posedge clk) begin
        if (state_reg == CTL_WRITE && bus_done) begin
            shadow_mem[idx_reg] <= cur_byte;
        end
    end

    k054000_bus_cycle #(
        .STROBE_CYCLES(STROBE_CYCLES),
        .READ_CYCLES  (READ_CYCLES)
    ) u_bus (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .rw     (go_rd),
        .addr   (go_addr),
        .data   (cur_byte),
        .d0_in  (d0_in),
        .busy   (bus_busy),
        .done   (bus_done),
        .sampled(hit),
        .a      (a),
        .d_out  (d_out),
        .d_oe   (d_oe),
        .cs     (cs),
        .nwr    (nwr)
    );

endmodule

// File: tb/tb_k054000_master.sv
// Directed bench for k054000_master with a behavioural 054000 target that
// latches writes on the rising edge of NWR and answers D0 from its registers.
module tb_k054000_master;

    logic        clk = 1'b0;
    logic        reset, start, full;
    logic [23:0] x_a, y_a, x_b, y_b;
    logic [7:0]  x_c, x_d, x_e, y_c, y_d, y_e;
    logic        busy, done, hit, d_oe, d0_in, cs, nwr;
    logic [4:0]  a;
    logic [7:0]  d_out;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    localparam logic [4:0] EXP_ADDR [18] = '{
        5'h01, 5'h02, 5'h03, 5'h04, 5'h06, 5'h0E, 5'h15, 5'h16, 5'h17,
        5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h07, 5'h0F, 5'h11, 5'h12, 5'h13
    };

    k054000_master dut (
        .clk(clk), .reset(reset), .start(start), .full(full),
        .x_a(x_a), .y_a(y_a), .x_b(x_b), .y_b(y_b),
        .x_c(x_c), .x_d(x_d), .x_e(x_e), .y_c(y_c), .y_d(y_d), .y_e(y_e),
        .busy(busy), .done(done), .hit(hit), .a(a), .d_out(d_out), .d_oe(d_oe),
        .d0_in(d0_in), .cs(cs), .nwr(nwr)
    );

    always #5 clk = ~clk;

    // Target model and bus monitors
    logic [7:0] tgt [32];
    logic       model_hit = 1'b0;
    logic [4:0] wr_addr [64];
    logic [7:0] wr_data [64];
    int         wr_len  [64];
    int         wr_n = 0, low_cnt = 0, rd_clks = 0, viol = 0, done_cnt = 0;

    assign d0_in = model_hit;

    function automatic logic [23:0] absdiff(input logic [23:0] p, input logic [23:0] q);
        return (p > q) ? p - q : q - p;
    endfunction

    always @(posedge nwr) begin
        if (cs === 1'b1) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = a;
                wr_data[wr_n] = d_out;
                wr_len[wr_n]  = low_cnt;
            end
            wr_n++;
            tgt[a] = d_out;
            model_hit = (absdiff({tgt[1], tgt[2], tgt[3]}, {tgt[21], tgt[22], tgt[23]})
                         <= 24'(tgt[14]) + 24'(tgt[4])) &&
                        (absdiff({tgt[9], tgt[10], tgt[11]}, {tgt[17], tgt[18], tgt[19]})
                         <= 24'(tgt[15]) + 24'(tgt[12]));
        end
        low_cnt = 0;
    end

    always @(negedge clk) begin
        if (cs === 1'b1 && nwr === 1'b0) low_cnt++;
        if (cs === 1'b1 && nwr === 1'b1 && d_oe === 1'b0 && a == 5'h18) rd_clks++;
        if (reset === 1'b0 && cs === 1'b1 && nwr === 1'b1 && d_oe === 1'b1 && a == 5'h18) viol++;
        if (done === 1'b1) done_cnt++;
    end

    always @(d_oe) begin
        if (reset === 1'b0 && nwr === 1'b0) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [7:0] t [18];
        t = '{x_a[23:16], x_a[15:8], x_a[7:0], x_e, x_d, x_c,
              x_b[23:16], x_b[15:8], x_b[7:0],
              y_a[23:16], y_a[15:8], y_a[7:0], y_e, y_d, y_c,
              y_b[23:16], y_b[15:8], y_b[7:0]};
        return t[i];
    endfunction

    task automatic do_txn(input logic f, input int exp_lat, input logic exp_hit,
                          input int exp_wr, input string tag);
        int n;
        bit seen;
        wr_n = 0; rd_clks = 0; low_cnt = 0;
        full = f; start = 1'b1; n = 1; seen = 0;
        @(posedge clk); #1;
        start = 1'b0; n = 2;
        while (!seen && n < 300) begin
            if (done === 1'b1) seen = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " hit"}, 32'(hit), 32'(exp_hit));
        chk({tag, " busy low at done"}, 32'(busy), 32'd0);
        chk({tag, " write count"}, 32'(wr_n), 32'(exp_wr));
        chk({tag, " read clocks"}, 32'(rd_clks), 32'd2);
        $display("txn %s: latency %0d hit %0b writes %0d", tag, n, hit, wr_n);
        @(posedge clk); #1;
        chk({tag, " done one pulse"}, 32'(done), 32'd0);
    endtask

    task automatic check_full_log(input string tag);
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("%s wr%0d addr", tag, i), 32'(wr_addr[i]), 32'(EXP_ADDR[i]));
            chk($sformatf("%s wr%0d data", tag, i), 32'(wr_data[i]), 32'(exp_byte(i)));
            chk($sformatf("%s wr%0d strobe", tag, i), 32'(wr_len[i]), 32'd2);
        end
    endtask

    initial begin
        int n;
        int d0;
        for (int i = 0; i < 32; i++) tgt[i] = 8'h00;
        reset = 1'b1; start = 1'b0; full = 1'b0;
        x_a = 24'h000100; x_b = 24'h000120; x_c = 8'h40; x_d = 8'h10; x_e = 8'h10;
        y_a = 24'h000100; y_b = 24'h000110; y_c = 8'h30; y_d = 8'h08; y_e = 8'h18;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset hit", 32'(hit), 32'd0);
        chk("reset cs", 32'(cs), 32'd0);
        chk("reset nwr", 32'(nwr), 32'd1);
        chk("reset d_oe", 32'(d_oe), 32'd0);
        chk("reset a", 32'(a), 32'd0);
        chk("reset d_out", 32'(d_out), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // First use after reset: every byte written, objects overlap
        do_txn(1'b0, 94, 1'b1, 18, "first");
        check_full_log("first");

        // Identical request: nothing to write, read only
        do_txn(1'b0, 22, 1'b1, 0, "repeat");

        // Only X_C changes: single write to 0E, overlap lost (0x20 > 0x08+0x10)
        x_c = 8'h08;
        do_txn(1'b0, 26, 1'b0, 1, "xc only");
        chk("xc only addr", 32'(wr_addr[0]), 32'h0E);
        chk("xc only data", 32'(wr_data[0]), 32'h08);
        chk("xc only strobe", 32'(wr_len[0]), 32'd2);

        // FULL forces all writes; object 2 far away
        x_c = 8'h40; x_b = 24'h800000;
        do_txn(1'b1, 94, 1'b0, 18, "full far");
        check_full_log("full far");

        // START held high while busy; inputs changed after acceptance
        wr_n = 0; rd_clks = 0; d0 = done_cnt;
        full = 1'b0; start = 1'b1; n = 1;
        @(posedge clk); #1;
        n = 2; x_c = 8'h08;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            chk($sformatf("held start busy c%0d", n), 32'(busy), 32'd1);
        end
        start = 1'b0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held start latency", 32'(n), 32'd22);
        chk("held start writes", 32'(wr_n), 32'd0);
        chk("held start read clocks", 32'(rd_clks), 32'd2);
        chk("held start hit", 32'(hit), 32'd0);
        $display("txn held start: latency %0d hit %0b writes %0d", n, hit, wr_n);
        repeat (3) @(posedge clk);
        #1;
        chk("held start done count", 32'(done_cnt - d0), 32'd1);
        chk("held start idle", 32'(busy), 32'd0);

        // Reset during a write strobe
        x_c = 8'h40; x_b = 24'h000120; full = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 0;
        while (nwr !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached strobe", 32'(nwr), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("abort nwr", 32'(nwr), 32'd1);
        chk("abort cs", 32'(cs), 32'd0);
        chk("abort d_oe", 32'(d_oe), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hit", 32'(hit), 32'd0);
        $display("txn abort: reset during strobe");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_txn(1'b0, 94, 1'b1, 18, "after reset");
        check_full_log("after reset");

        chk("bus invariants", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/k054000_master.md
# k054000_master

Bus-initiator sequencer for the 054000 collision checker. It takes two object descriptors per axis from a host-side request, writes the 18 parameter registers over the 8-bit chip bus, and reads back the collision bit. It sits between game-logic RTL (or a CPU shim) and a 054000 target strapped for separate-strobe mode (P20=1). It tracks shadow copies of the registers, so repeat requests only rewrite the bytes that changed.

## Interface
- STROBE_CYCLES, 2: clocks NWR is held low per write (≥1)
- READ_CYCLES, 2: clocks CS is held high before D0 is sampled (≥1)
- CLK  in  1  single clock; all state on rising edge
- RESET  in  1  asynchronous, active-high
- START  in  1  request pulse; accepted only when BUSY=0
- FULL  in  1  sampled with START; 1 forces all 18 writes
- X_A, Y_A  in  24 each  object-1 position terms
- X_B, Y_B  in  24 each  object-2 position terms
- X_C, X_D, X_E, Y_C, Y_D, Y_E  in  8 each  size/extent terms
- BUSY  out  1  transaction in progress
- DONE  out  1  one-clock pulse when HIT is updated
- HIT  out  1  last collision result, held until the next DONE
- A  out  5  chip address A[5:1]
- D_OUT  out  8  write data
- D_OE  out  1  1 = master drives D
- D0_IN  in  1  chip D0 readback
- CS  out  1  to P26, active-high
- NWR  out  1  to P27, active-low

## Operation
- Register map as {address: value}, issued in this order:
  - X side: 01,02,03: X_A[23:16],[15:8],[7:0]; 04: X_E; 06: X_D; 0E: X_C; 15,16,17: X_B MSB→LSB.
  - Y side: 09,0A,0B: Y_A; 0C: Y_E; 07: Y_D; 0F: Y_C; 11,12,13: Y_B.
  - Read address: 18.
- On accepted START, all inputs are latched into a request buffer. Later input changes do not affect the transaction in progress.
- A write is required for an index if FULL=1, if the shadow is invalid (first use after reset), or if the latched byte differs from its shadow. After a write completes, its shadow byte is updated.
- States:
  - IDLE: waits for an accepted START, then goes to SCAN.
  - SCAN: advances index 0..17 one per clock, skipping bytes that need no write. Goes to W_SETUP when a write is needed, and to R_ACC after index 17.
  - W_SETUP → W_STROBE → W_HOLD: one bus write, then back to SCAN at index+1.
  - R_ACC → R_SAMPLE: bus read, then IDLE.
- Read always occurs, even if zero writes were needed.
- Shadow valid is set when the first transaction completes. Reset clears it.

## Timing
- Reset values: BUSY=0, DONE=0, HIT=0, CS=0, NWR=1, D_OE=0, A=0, D_OUT=0, all shadows invalid.
- BUSY rises the clock after START is accepted. It falls in the same clock DONE pulses.
- Write cycle:
  - W_SETUP (1 clk): A, D_OUT, D_OE=1 and CS=1 become valid; NWR=1.
  - W_STROBE (STROBE_CYCLES clk): NWR=0.
  - W_HOLD (1 clk): NWR=1, while A, D_OUT, D_OE and CS are held. The target latches are transparent, so data must be stable across the rising edge of NWR.
  - CS falls and D_OE falls at the end of W_HOLD.
- Read cycle:
  - R_ACC (READ_CYCLES clk): A=18 (binary 11000), CS=1, NWR=1, D_OE=0.
  - D0_IN is registered into HIT at the end of the last R_ACC clock.
  - R_SAMPLE: CS=0 and DONE=1.
- The bus never drives D_OE=1 while CS=1 and NWR=1 are in read mode. D_OE never changes while NWR=0.
- Latency, defaults, full rewrite: 1 (SCAN entry) + 18×(1 SCAN + 4 bus) + 2 + 1 = 94 clocks from START to DONE. With no writes needed: 1 + 18 + 3 = 22 clocks.
- START while BUSY=1 is ignored and not queued.
- RESET mid-transaction: everything returns to reset values immediately and asynchronously (NWR=1, CS=0). Shadows are invalidated, because the target contents are unknown.

## Structure
- Package k054000_pkg holds:
  - the 18-entry address ROM constant plus READ_ADDR=5'h18;
  - the state enum;
  - a function mapping index→request byte.
- Sub-module k054000_bus_cycle drives one write or read: go/rw/addr/data in; busy/done/sampled-bit out; owns CS/NWR/D_OE timing and both cycle parameters. The top level owns the buffer, shadows, SCAN and result.

## Test plan
- Reset, START with FULL=0, X_A=000100, Y_A=000100, objects overlapping in the target model → 18 writes in map order, each with NWR low for 2 clk; DONE at clock 94; HIT=1.
- Repeat the same request → zero writes, one read at A=18, DONE at clock 22, HIT=1.
- Change only X_C → exactly one write (addr 0E, new value), then the read.
- Move object 2 far away (X_B=800000) with FULL=1 → 18 writes, HIT=0.
- Assert START every clock while BUSY → only the first is accepted; no bus activity overlaps.
- Assert RESET during W_STROBE → NWR=1 and CS=0 the same cycle. The next START performs 18 writes, even with FULL=0.
